// File: rtl/snoop_adapter_if.sv
// snoop_adapter_if: bundle of all non-clock signals around the snoop adapter.
//
// Signal groups:
//   sn_*      32-bit big-endian packet stream from the snooper (valid/ready)
//   wr_*      packet RAM write port (word address, word data, strobe)
//   rdy/rdy_ack, done/done_ack, byte_len, trunc
//             handshake and result towards the ping-pong buffer manager
//
// Modports:
//   slave   the adapter itself
//   master  the environment (snooper, RAM and buffer manager side)

interface snoop_adapter_if #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned PLEN_WIDTH = 32
);

    // Snooper stream
    logic [31:0]           sn_data;
    logic                  sn_vld;
    logic                  sn_last;
    logic [1:0]            sn_bytes;
    logic                  sn_rdy;

    // Packet RAM write port
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;

    // Buffer manager handshake and packet result
    logic [PLEN_WIDTH-1:0] byte_len;
    logic                  trunc;
    logic                  rdy;
    logic                  rdy_ack;
    logic                  done;
    logic                  done_ack;

    modport slave (
        input  sn_data,
        input  sn_vld,
        input  sn_last,
        input  sn_bytes,
        output sn_rdy,
        output wr_addr,
        output wr_data,
        output wr_en,
        output byte_len,
        output trunc,
        input  rdy,
        output rdy_ack,
        output done,
        input  done_ack
    );

    modport master (
        output sn_data,
        output sn_vld,
        output sn_last,
        output sn_bytes,
        input  sn_rdy,
        input  wr_addr,
        input  wr_data,
        input  wr_en,
        input  byte_len,
        input  trunc,
        output rdy,
        input  rdy_ack,
        input  done,
        output done_ack
    );

endinterface

// File: rtl/snoop_adapter.sv
// snoop_adapter: write side of the packet memory.
//
// Accepts a 32-bit big-endian beat stream from the snooper, packs K = DATA_WIDTH/32 beats
// per memory word (first beat in the MSBs), writes the words at consecutive word addresses
// starting at 0 and counts the packet length in bytes (saturating at the memory capacity).
// A buffer is claimed from the ping-pong manager with rdy/rdy_ack before the packet and
// returned with done/done_ack after the last word has been written.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset; all outputs drop to 0 immediately
//   bus   snoop_adapter_if.slave: sn_* stream in, wr_* RAM port out, buffer handshake,
//         byte_len / trunc result (valid while done is high)

module snoop_adapter #(
    parameter int unsigned BYTE_ADDR_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH      = 9,
    parameter int unsigned DATA_WIDTH      = (2 ** (BYTE_ADDR_WIDTH - ADDR_WIDTH)) * 8,
    parameter int unsigned PLEN_WIDTH      = 32
) (
    input  logic           clk,
    input  logic           rst,
    snoop_adapter_if.slave bus
);

    localparam int unsigned K    = DATA_WIDTH / 32;
    localparam int unsigned IdxW = (K > 1) ? $clog2(K) : 1;

    localparam logic [IdxW-1:0]       LastIdx  = IdxW'(K - 1);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;
    localparam logic [PLEN_WIDTH-1:0] Cap      = PLEN_WIDTH'(1) << BYTE_ADDR_WIDTH;

    if ((DATA_WIDTH % 32) != 0 || DATA_WIDTH < 32) begin : g_bad_data_width
        $error("snoop_adapter: DATA_WIDTH must be a non-zero multiple of 32");
    end
    if (PLEN_WIDTH <= BYTE_ADDR_WIDTH) begin : g_bad_plen_width
        $error("snoop_adapter: PLEN_WIDTH must exceed BYTE_ADDR_WIDTH");
    end

    typedef enum logic [1:0] {
        StWaitBuf,
        StFill,
        StFlush,
        StDone
    } state_e;

    state_e                state_q;
    logic [IdxW-1:0]       idx_q;
    logic [DATA_WIDTH-1:0] pack_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    // Set once the last word address has been written; later words are dropped.
    logic                  full_q;
    logic [PLEN_WIDTH-1:0] count_q;
    logic                  trunc_q;

    logic                  sn_rdy_q;
    logic                  rdy_ack_q;
    logic                  done_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    // Beat decode and next pack word
    logic                  beat_fire;
    logic                  word_end;
    logic [2:0]            beat_bytes;
    logic [31:0]           beat_mask;
    logic [31:0]           beat_data;
    logic [DATA_WIDTH-1:0] word_next;
    logic [PLEN_WIDTH-1:0] count_sum;

    always_comb begin
        beat_fire = bus.sn_vld & sn_rdy_q;
        word_end  = bus.sn_last | (idx_q == LastIdx);

        beat_bytes = 3'd4;
        if (bus.sn_last && bus.sn_bytes != 2'd0) begin
            beat_bytes = {1'b0, bus.sn_bytes};
        end

        // Keep only the leading (most significant) valid bytes of the last beat.
        unique case (beat_bytes)
            3'd1:    beat_mask = 32'hFF00_0000;
            3'd2:    beat_mask = 32'hFFFF_0000;
            3'd3:    beat_mask = 32'hFFFF_FF00;
            default: beat_mask = 32'hFFFF_FFFF;
        endcase
        beat_data = bus.sn_data & beat_mask;

        // Beat idx lands in lane K-1-idx so the first beat occupies the MSBs.
        word_next = pack_q;
        for (int unsigned l = 0; l < K; l++) begin
            if (IdxW'(K - 1 - l) == idx_q) begin
                word_next[32*l +: 32] = beat_data;
            end
        end

        count_sum = count_q + PLEN_WIDTH'(beat_bytes);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StWaitBuf;
            idx_q     <= '0;
            pack_q    <= '0;
            addr_q    <= '0;
            full_q    <= 1'b0;
            count_q   <= '0;
            trunc_q   <= 1'b0;
            sn_rdy_q  <= 1'b0;
            rdy_ack_q <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rdy_ack_q <= 1'b0;
            wr_en_q   <= 1'b0;

            unique case (state_q)
                StWaitBuf: begin
                    if (bus.rdy) begin
                        rdy_ack_q <= 1'b1;
                        sn_rdy_q  <= 1'b1;
                        idx_q     <= '0;
                        pack_q    <= '0;
                        addr_q    <= '0;
                        full_q    <= 1'b0;
                        count_q   <= '0;
                        trunc_q   <= 1'b0;
                        state_q   <= StFill;
                    end
                end

                StFill: begin
                    if (beat_fire) begin
                        if (count_sum > Cap) begin
                            count_q <= Cap;
                            trunc_q <= 1'b1;
                        end else begin
                            count_q <= count_sum;
                        end

                        if (word_end) begin
                            // Beats past capacity are still drained, just not written.
                            wr_en_q   <= ~full_q;
                            wr_addr_q <= addr_q;
                            wr_data_q <= word_next;
                            pack_q    <= '0;
                            idx_q     <= '0;
                            if (!full_q) begin
                                if (addr_q == LastAddr) begin
                                    full_q <= 1'b1;
                                end else begin
                                    addr_q <= addr_q + 1'b1;
                                end
                            end
                        end else begin
                            pack_q <= word_next;
                            idx_q  <= idx_q + 1'b1;
                        end

                        if (bus.sn_last) begin
                            sn_rdy_q <= 1'b0;
                            state_q  <= StFlush;
                        end
                    end
                end

                // The final write registered by the last beat is on the port this cycle.
                StFlush: begin
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end

                StDone: begin
                    if (bus.done_ack) begin
                        done_q  <= 1'b0;
                        state_q <= StWaitBuf;
                    end
                end

                default: begin
                    state_q <= StWaitBuf;
                end
            endcase
        end
    end

    assign bus.sn_rdy   = sn_rdy_q;
    assign bus.rdy_ack  = rdy_ack_q;
    assign bus.done     = done_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.byte_len = count_q;
    assign bus.trunc    = trunc_q;

endmodule
